// File: rtl/band_mixer.sv
// Three-band recombination for the equalizer: per-band gain, sum, arithmetic
// shift and 16-bit saturation, with one multiplier shared across the bands.
module band_mixer #(
    parameter int AUDIO_DEPTH = 16,
    parameter int GAIN_WIDTH  = 8,
    parameter int GAIN_FRAC   = 5,
    parameter int GAIN_RESET  = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    input  logic signed [AUDIO_DEPTH-1:0] low_band,
    input  logic signed [AUDIO_DEPTH-1:0] mid_band,
    input  logic signed [AUDIO_DEPTH-1:0] high_band,
    input  logic                          gain_we,
    input  logic [1:0]                    gain_sel,
    input  logic [GAIN_WIDTH-1:0]         gain_data,
    output logic signed [AUDIO_DEPTH-1:0] audio_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          clip
);

    localparam int PROD_W = AUDIO_DEPTH + GAIN_WIDTH + 1;
    localparam int ACC_W  = AUDIO_DEPTH + GAIN_WIDTH + 3;
    localparam int MAX_V  = 2**(AUDIO_DEPTH-1) - 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(MAX_V);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-MAX_V - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    logic [1:0]                    state_reg;
    logic [1:0]                    idx_reg;
    logic signed [ACC_W-1:0]       acc_reg;
    logic signed [AUDIO_DEPTH-1:0] audio_reg;
    logic                          clip_reg;

    logic signed [AUDIO_DEPTH-1:0] band_in   [0:2];
    logic signed [AUDIO_DEPTH-1:0] band_cap  [0:2];
    logic [GAIN_WIDTH-1:0]         gain_cur  [0:2];
    logic [GAIN_WIDTH-1:0]         gain_snap [0:2];

    logic                          accept;
    logic signed [AUDIO_DEPTH-1:0] cur_band;
    logic [GAIN_WIDTH-1:0]         cur_gain;
    logic signed [PROD_W-1:0]      product;
    logic signed [ACC_W-1:0]       acc_sum;
    logic signed [ACC_W-1:0]       shifted;
    logic signed [AUDIO_DEPTH-1:0] sat_val;
    logic                          sat_clip;

    assign band_in[0] = low_band;
    assign band_in[1] = mid_band;
    assign band_in[2] = high_band;

    assign accept = (state_reg == ST_IDLE) && sample_valid;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_band
            logic [GAIN_WIDTH-1:0]         gain_reg;
            logic [GAIN_WIDTH-1:0]         snap_reg;
            logic signed [AUDIO_DEPTH-1:0] band_reg;

            // The snapshot samples gain_reg before any same-edge write lands.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    gain_reg <= GAIN_WIDTH'(GAIN_RESET);
                    snap_reg <= '0;
                    band_reg <= '0;
                end else begin
                    if (gain_we && (gain_sel == 2'(gi)))
                        gain_reg <= gain_data;
                    if (accept) begin
                        snap_reg <= gain_reg;
                        band_reg <= band_in[gi];
                    end
                end
            end

            assign gain_cur[gi]  = gain_reg;
            assign gain_snap[gi] = snap_reg;
            assign band_cap[gi]  = band_reg;
        end
    endgenerate

    always_comb begin
        cur_band = band_cap[0];
        cur_gain = gain_snap[0];
        case (idx_reg)
            2'd1:    begin cur_band = band_cap[1]; cur_gain = gain_snap[1]; end
            2'd2:    begin cur_band = band_cap[2]; cur_gain = gain_snap[2]; end
            default: begin cur_band = band_cap[0]; cur_gain = gain_snap[0]; end
        endcase
    end

    // Gain is unsigned, so it is zero-extended before the signed multiply.
    assign product = cur_band * $signed({1'b0, cur_gain});
    assign acc_sum = acc_reg + {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
    assign shifted = acc_sum >>> GAIN_FRAC;

    always_comb begin
        sat_val  = shifted[AUDIO_DEPTH-1:0];
        sat_clip = 1'b0;
        if (shifted > SAT_MAX) begin
            sat_val  = SAT_MAX[AUDIO_DEPTH-1:0];
            sat_clip = 1'b1;
        end else if (shifted < SAT_MIN) begin
            sat_val  = SAT_MIN[AUDIO_DEPTH-1:0];
            sat_clip = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            idx_reg   <= 2'd0;
            acc_reg   <= '0;
            audio_reg <= '0;
            clip_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (sample_valid) begin
                        acc_reg   <= '0;
                        idx_reg   <= 2'd0;
                        state_reg <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc_reg <= acc_sum;
                    idx_reg <= idx_reg + 2'd1;
                    if (idx_reg == 2'd2) begin
                        audio_reg <= sat_val;
                        clip_reg  <= sat_clip;
                        state_reg <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (out_ready)
                        state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign sample_ready = (state_reg == ST_IDLE);
    assign out_valid    = (state_reg == ST_OUT);
    assign audio_out    = audio_reg;
    assign clip         = clip_reg;

endmodule

// File: tb/tb_band_mixer.sv
// Directed bench for band_mixer: expected mixes are queued at accept time from
// a local gain model and checked when the output handshake completes.
module tb_band_mixer;

    logic               clk = 1'b0;
    logic               reset;
    logic               sample_valid;
    logic               sample_ready;
    logic signed [15:0] low_band, mid_band, high_band;
    logic               gain_we;
    logic [1:0]         gain_sel;
    logic [7:0]         gain_data;
    logic signed [15:0] audio_out;
    logic               out_valid;
    logic               out_ready;
    logic               clip;

    band_mixer dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .low_band     (low_band),
        .mid_band     (mid_band),
        .high_band    (high_band),
        .gain_we      (gain_we),
        .gain_sel     (gain_sel),
        .gain_data    (gain_data),
        .audio_out    (audio_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .clip         (clip)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [31:0] val;
        logic signed [31:0] clp;
    } exp_t;

    exp_t sb[$];
    int   gm[3];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int l, input int m, input int h);
        exp_t e;
        int   sum;
        int   sh;
        sum = l * gm[0] + m * gm[1] + h * gm[2];
        sh  = sum >>> 5;
        e.clp = 0;
        if (sh > 32767) begin
            sh = 32767;
            e.clp = 1;
        end else if (sh < -32768) begin
            sh = -32768;
            e.clp = 1;
        end
        e.val = sh;
        return e;
    endfunction

    // Called at #1 after a rising edge; the write lands on the next edge.
    task automatic write_gain(input logic [1:0] sel, input logic [7:0] data);
        gain_we   = 1'b1;
        gain_sel  = sel;
        gain_data = data;
        @(posedge clk); #1;
        gain_we = 1'b0;
        if (sel != 2'd3) gm[sel] = int'(data);
    endtask

    task automatic accept(input int l, input int m, input int h,
                          input bit wr = 1'b0, input logic [1:0] wsel = 2'd0,
                          input logic [7:0] wdata = 8'd0);
        int wait_cnt;
        wait_cnt = 0;
        while (!sample_ready && wait_cnt < 20) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        if (!sample_ready) check("ready_timeout", 0, 1);
        sample_valid = 1'b1;
        low_band  = l[15:0];
        mid_band  = m[15:0];
        high_band = h[15:0];
        sb.push_back(model(l, m, h));
        if (wr) begin
            gain_we   = 1'b1;
            gain_sel  = wsel;
            gain_data = wdata;
        end
        @(posedge clk); #1;
        sample_valid = 1'b0;
        gain_we      = 1'b0;
        if (wr && wsel != 2'd3) gm[wsel] = int'(wdata);
        check("accepted", {31'd0, sample_ready}, 0);
    endtask

    task automatic collect(input string tag, input int start_cnt, input int hold);
        int                 cnt;
        exp_t               e;
        logic signed [15:0] held_val;
        logic               held_clip;
        bit                 stable;
        cnt = start_cnt;
        while (!out_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        e = sb.pop_front();
        if (!out_valid) begin
            check("out_valid_timeout", 0, 1);
            return;
        end
        check("latency", cnt, 3);
        check({tag, "_audio"}, 32'(audio_out), e.val);
        check({tag, "_clip"}, {31'd0, clip}, e.clp);
        if (hold > 0) begin
            held_val  = audio_out;
            held_clip = clip;
            stable    = 1'b1;
            for (int i = 0; i < hold; i++) begin
                sample_valid = (i == 4);
                low_band     = 16'sd7;
                @(posedge clk); #1;
                if (!out_valid || sample_ready || audio_out !== held_val || clip !== held_clip)
                    stable = 1'b0;
            end
            sample_valid = 1'b0;
            check("bp_stable", {31'd0, stable}, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("valid_drop", {31'd0, out_valid}, 0);
        check("ready_back", {31'd0, sample_ready}, 1);
        $display("txn %s audio_out=%0d clip=%0d expected=%0d/%0d", tag, audio_out, clip, e.val, e.clp);
    endtask

    initial begin
        bit seen_valid;
        reset        = 1'b1;
        sample_valid = 1'b0;
        low_band     = '0;
        mid_band     = '0;
        high_band    = '0;
        gain_we      = 1'b0;
        gain_sel     = 2'd0;
        gain_data    = 8'd0;
        out_ready    = 1'b0;
        gm           = '{32, 32, 32};
        repeat (3) @(posedge clk);
        #1;
        check("rst_audio", 32'(audio_out), 0);
        check("rst_valid", {31'd0, out_valid}, 0);
        check("rst_clip", {31'd0, clip}, 0);
        check("rst_ready", {31'd0, sample_ready}, 1);
        reset = 1'b0;
        @(posedge clk); #1;

        accept(1000, 1000, 1000);
        collect("unity", 0, 0);
        accept(32767, 32767, 32767);
        collect("sat_pos", 0, 0);
        accept(-32768, -32768, -32768);
        collect("sat_neg", 0, 0);
        write_gain(2'd0, 8'd64);
        accept(20000, 0, 0);
        collect("sat_gain64", 0, 0);

        // Reset mid-MAC while the previous output was saturated and clipped.
        accept(5, 5, 5);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("midrst_audio", 32'(audio_out), 0);
        check("midrst_valid", {31'd0, out_valid}, 0);
        check("midrst_clip", {31'd0, clip}, 0);
        check("midrst_ready", {31'd0, sample_ready}, 1);
        void'(sb.pop_back());
        gm = '{32, 32, 32};
        @(posedge clk); #1;
        reset = 1'b0;
        seen_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid = 1'b1;
        end
        check("midrst_no_output", {31'd0, seen_valid}, 0);
        accept(100, 200, 300);
        collect("post_reset", 0, 0);

        write_gain(2'd0, 8'd16);
        write_gain(2'd1, 8'd16);
        write_gain(2'd2, 8'd16);
        accept(1, 1, 1);
        collect("floor_sum", 0, 0);
        accept(3, 0, 0);
        collect("floor_pos", 0, 0);
        accept(-3, 0, 0);
        collect("floor_neg", 0, 0);

        write_gain(2'd0, 8'd32);
        write_gain(2'd1, 8'd32);
        write_gain(2'd2, 8'd32);
        accept(1000, 0, 0, 1'b1, 2'd0, 8'd0);
        collect("wr_on_accept", 0, 0);
        accept(1000, 0, 0);
        collect("after_accept_wr", 0, 0);
        write_gain(2'd0, 8'd32);
        accept(2000, 0, 0);
        write_gain(2'd0, 8'd0);
        collect("wr_in_mac", 1, 0);
        accept(2000, 0, 0);
        collect("after_mac_wr", 0, 0);
        write_gain(2'd3, 8'd200);
        accept(500, 500, 500);
        collect("sel3_ignored", 0, 0);

        accept(123, -456, 789);
        collect("backpressure", 0, 10);

        for (int k = 0; k < 4; k++) begin
            write_gain(2'd0, 8'($urandom));
            write_gain(2'd1, 8'($urandom));
            write_gain(2'd2, 8'($urandom));
            accept(int'($signed(16'($urandom))), int'($signed(16'($urandom))),
                   int'($signed(16'($urandom))));
            collect("random", 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
